// File: rtl/sevenseg_scan_ctrl.sv
// Scan scheduler for a multiplexed common-anode seven-segment display.
// Snapshots a frame of BCD digits, then walks the slots with a blank gap and an ON dwell per slot.
module sevenseg_scan_ctrl #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned ON_CYCLES    = 2500,
    parameter int unsigned BLANK_CYCLES = 50
) (
    input  logic                  clk_5MHz,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [3:0]            bcd_out,
    output logic                  dp_out,
    output logic                  blank_out,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [2:0]            digit_idx,
    output logic                  frame_start
);

    localparam int unsigned         CNT_W      = 16;
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [2:0]          LAST_IDX   = 3'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0   = N_DIGITS'(1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_BLANK,
        S_ON
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_en;
    logic [N_DIGITS-1:0]   snap_dp;
    logic                  snap_lz;
    logic [N_DIGITS-1:0]   visible;
    logic                  upper_zero;
    logic [2:0]            next_idx;

    // A slot is suppressed when it and every more-significant digit is zero; slot 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        visible    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (snap_digits[4*i +: 4] == 4'h0);
            visible[i] = snap_en[i] & ~(snap_lz & (i != 0) & upper_zero);
        end
    end

    assign next_idx = digit_idx + 3'd1;

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            state       <= S_LOAD;
            cnt         <= '0;
            snap_digits <= '0;
            snap_en     <= '0;
            snap_dp     <= '0;
            snap_lz     <= 1'b0;
            digit_idx   <= '0;
            bcd_out     <= '0;
            dp_out      <= 1'b0;
            blank_out   <= 1'b1;
            anodes      <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                S_LOAD: begin
                    snap_digits <= digits_in;
                    snap_en     <= digit_en;
                    snap_dp     <= dp_in;
                    snap_lz     <= lz_blank;
                    digit_idx   <= '0;
                    cnt         <= '0;
                    frame_start <= 1'b1;
                    anodes      <= '1;
                    blank_out   <= 1'b1;
                    // Slot 0 is never suppressed, so its preload only depends on enable.
                    bcd_out     <= digits_in[3:0];
                    dp_out      <= dp_in[0] & digit_en[0];
                    state       <= S_BLANK;
                end
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= S_ON;
                        if (visible[digit_idx]) begin
                            anodes    <= ~(ONE_HOT0 << digit_idx);
                            blank_out <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        cnt       <= '0;
                        anodes    <= '1;
                        blank_out <= 1'b1;
                        if (digit_idx == LAST_IDX) begin
                            dp_out <= 1'b0;
                            state  <= S_LOAD;
                        end else begin
                            digit_idx <= next_idx;
                            bcd_out   <= snap_digits[4*next_idx +: 4];
                            // dp is gated by visibility so a hidden slot never raises it.
                            dp_out    <= snap_dp[next_idx] & visible[next_idx];
                            state     <= S_BLANK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with 8 digits, 4-cycle ON and 2-cycle blank (49-cycle frame).
module tb_sevenseg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] digits_in;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic        blank_out;
    logic [7:0]  anodes;
    logic [2:0]  digit_idx;
    logic        frame_start;

    sevenseg_scan_ctrl #(
        .N_DIGITS    (8),
        .ON_CYCLES   (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk_5MHz   (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .blank_out  (blank_out),
        .anodes     (anodes),
        .digit_idx  (digit_idx),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-frame observation results
    logic [7:0]  r_lit;
    logic [31:0] r_shown;
    logic [7:0]  r_dpm;
    logic        r_dpany;
    int          r_period;
    int          r_litc;

    // Called right after frame_start was observed; returns on the next frame_start.
    task automatic scan_frame(input int chg_slot, input logic [31:0] chg_val);
        r_lit = '0; r_shown = '0; r_dpm = '0; r_dpany = 1'b0; r_period = 0; r_litc = 0;
        do begin
            tick();
            r_period++;
            if (dp_out) r_dpany = 1'b1;
            if (anodes != 8'hFF) begin
                r_litc++;
                for (int s = 0; s < 8; s++) begin
                    if (!anodes[s]) begin
                        r_lit[s] = 1'b1;
                        r_shown[4*s +: 4] = bcd_out;
                        if (dp_out) r_dpm[s] = 1'b1;
                    end
                end
                if (chg_slot >= 0 && int'(digit_idx) == chg_slot) digits_in = chg_val;
            end
        end while (!frame_start && r_period < 200);
        if (!frame_start) check("frame_timeout", 32'(frame_start), 32'd1);
    endtask

    task automatic run_cfg(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp,
                           input logic lz);
        digits_in = d; digit_en = en; dp_in = dp; lz_blank = lz;
        scan_frame(-1, 32'h0);
        scan_frame(-1, 32'h0);
    endtask

    // Continuous display-safety monitor
    logic mon_en = 1'b0;
    logic prev_lit = 1'b0;
    logic [7:0] prev_an = 8'hFF;
    int gap = 100;

    always @(negedge clk) begin
        if (mon_en) begin
            check("one_anode", 32'($countones(~anodes) <= 1), 32'd1);
            if (blank_out) check("blank_dark", 32'(anodes), 32'hFF);
            if (anodes != 8'hFF) begin
                if (prev_lit) check("adjacent_slots", 32'(anodes), 32'(prev_an));
                else          check("blank_gap", 32'(gap >= 2), 32'd1);
                gap = 0;
            end else begin
                gap++;
            end
            prev_lit = (anodes != 8'hFF);
            prev_an  = anodes;
        end
    end

    int  n;
    logic found;

    initial begin
        reset = 1'b1; digits_in = 32'h87654321; digit_en = 8'hFF; dp_in = 8'h00; lz_blank = 1'b0;
        #12;
        check("rst_anodes", 32'(anodes), 32'hFF);
        check("rst_blank",  32'(blank_out), 32'd1);
        check("rst_bcd",    32'(bcd_out), 32'd0);
        check("rst_idx",    32'(digit_idx), 32'd0);
        check("rst_fs",     32'(frame_start), 32'd0);
        check("rst_dp",     32'(dp_out), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // First frame, cycle-exact
        tick();
        check("c1_fs", 32'(frame_start), 32'd1);
        check("c1_anodes", 32'(anodes), 32'hFF);
        check("c1_bcd", 32'(bcd_out), 32'd1);
        tick();
        check("c2_fs", 32'(frame_start), 32'd0);
        check("c2_anodes", 32'(anodes), 32'hFF);
        tick();
        check("c3_anodes", 32'(anodes), 32'hFE);
        check("c3_bcd", 32'(bcd_out), 32'd1);
        check("c3_blank", 32'(blank_out), 32'd0);
        repeat (3) tick();
        check("c6_anodes", 32'(anodes), 32'hFE);
        tick();
        check("c7_anodes", 32'(anodes), 32'hFF);
        check("c7_idx", 32'(digit_idx), 32'd1);
        check("c7_bcd", 32'(bcd_out), 32'd2);
        repeat (2) tick();
        check("c9_anodes", 32'(anodes), 32'hFD);
        check("c9_bcd", 32'(bcd_out), 32'd2);
        n = 0;
        do begin tick(); n++; end while (!frame_start && n < 200);
        check("next_fs_cycle50", 32'(n), 32'd41);

        scan_frame(-1, 32'h0);
        check("f1_period", 32'(r_period), 32'd49);
        check("f1_lit", 32'(r_lit), 32'hFF);
        check("f1_shown", r_shown, 32'h87654321);
        check("f1_litc", 32'(r_litc), 32'd32);

        // Leading zeros: slot 1 holds an embedded zero below the 3, so it stays lit
        run_cfg(32'h00000305, 8'hFF, 8'h00, 1'b1);
        check("lz_lit", 32'(r_lit), 32'h07);
        check("lz_shown", r_shown, 32'h00000305);
        check("lz_litc", 32'(r_litc), 32'd12);
        check("lz_period", 32'(r_period), 32'd49);
        run_cfg(32'h00000305, 8'hFF, 8'h00, 1'b0);
        check("nolz_lit", 32'(r_lit), 32'hFF);
        check("nolz_shown", r_shown, 32'h00000305);

        run_cfg(32'h00000000, 8'hFF, 8'h00, 1'b1);
        check("allzero_lit", 32'(r_lit), 32'h01);
        check("allzero_shown", r_shown, 32'h0);

        run_cfg(32'h00000305, 8'hFF, 8'h80, 1'b1);
        check("lzdp_lit", 32'(r_lit), 32'h07);
        check("lzdp_dp", 32'(r_dpany), 32'd0);

        // Disabled slot with a dp request
        run_cfg(32'h87654321, 8'hFB, 8'h04, 1'b0);
        check("en_lit", 32'(r_lit), 32'hFB);
        check("en_shown", r_shown, 32'h87654021);
        check("en_dp", 32'(r_dpany), 32'd0);
        check("en_period", 32'(r_period), 32'd49);

        run_cfg(32'h87654321, 8'hFF, 8'h01, 1'b0);
        check("dp_mask", 32'(r_dpm), 32'h01);

        run_cfg(32'hFEDCBA98, 8'hFF, 8'h00, 1'b0);
        check("hex_shown", r_shown, 32'hFEDCBA98);

        run_cfg(32'h12345678, 8'h00, 8'hFF, 1'b0);
        check("off_litc", 32'(r_litc), 32'd0);
        check("off_period", 32'(r_period), 32'd49);
        check("off_dp", 32'(r_dpany), 32'd0);

        // Mid-frame input change is held off until the next snapshot
        run_cfg(32'h87654321, 8'hFF, 8'h00, 1'b0);
        scan_frame(3, 32'h11111111);
        check("tear_shown", r_shown, 32'h87654321);
        scan_frame(-1, 32'h0);
        check("tear_next", r_shown, 32'h11111111);

        // Asynchronous reset during slot 5 ON
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (digit_idx == 3'd5 && anodes != 8'hFF) found = 1'b1;
        end
        check("find_slot5", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_anodes", 32'(anodes), 32'hFF);
        check("arst_blank", 32'(blank_out), 32'd1);
        check("arst_idx", 32'(digit_idx), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        check("arst_fs", 32'(frame_start), 32'd1);
        check("arst_bcd", 32'(bcd_out), 32'd1);
        scan_frame(-1, 32'h0);
        check("arst_period", 32'(r_period), 32'd49);
        check("arst_shown", r_shown, 32'h11111111);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
